instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 153 +++++++++++++++
 tb/tb_instr_fetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Program sequencer feeding the CPU control FSM. It holds a small program
// memory, loaded while the sequencer is stopped, and presents one instruction
// at a time. It advances on the FSM's done pulse and stops on a HALT opcode.
// It supports free-run and single-step operation. The fetch PC here is
// independent of the datapath PC register (R7).
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   load_we      program-memory write strobe (honoured in IDLE/HALTED only)
//   load_addr    program-memory write address
//   load_data    program word to write
//   start        pulse: begin execution at address 0 (IDLE/HALTED only)
//   step_mode    1 = return to IDLE after each completed instruction
//   done         instruction-complete pulse from the control FSM
//   instruction  word presented to the control FSM (NOP unless issuing)
//   pc           address of the current or next fetch
//   busy         high in FETCH or ISSUE
//   halted       high in HALTED
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter  int OP_SIZE  = 4,
   parameter  int ARG_SIZE = 3,
   parameter  int ARG_NUM  = 2,
   parameter  int DEPTH    = 16,
   parameter  int ADDR_W   = 4,
   localparam int INSTR_W  = OP_SIZE + ARG_NUM * ARG_SIZE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_we,
   input  logic [ADDR_W-1:0]  load_addr,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               start,
   input  logic               step_mode,
   input  logic               done,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               halted
);

   localparam int ARGS_W = ARG_NUM * ARG_SIZE;

   localparam logic [OP_SIZE-1:0] HALT_OP = OP_SIZE'(4'b1111);
   localparam logic [OP_SIZE-1:0] NOP_OP  = OP_SIZE'(4'b1110);

   // The control FSM decodes the unknown NOP opcode as idle.
   localparam logic [INSTR_W-1:0] HALT_WORD = {HALT_OP, {ARGS_W{1'b0}}};
   localparam logic [INSTR_W-1:0] NOP_WORD  = {NOP_OP,  {ARGS_W{1'b0}}};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      ISSUE  = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t             state;
   logic [INSTR_W-1:0] ir;
   logic [INSTR_W-1:0] mem [DEPTH];

   logic [INSTR_W-1:0] fetch_word;
   logic               fetch_is_halt;
   logic               mem_we;

   // Asynchronous read of the word at the fetch address.
   assign fetch_word    = mem[pc];
   assign fetch_is_halt = (fetch_word[INSTR_W-1 -: OP_SIZE] == HALT_OP);

   // Loading is only allowed while the sequencer is stopped.
   assign mem_we = load_we && ((state == IDLE) || (state == HALTED));

   // NOTE: the program memory is deliberately reset: every word returns to
   // HALT, so an unloaded (or freshly reset) program halts at once. This makes
   // it a register array rather than a RAM macro.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= HALT_WORD;
         end
      end else if (mem_we) begin
         mem[load_addr] <= load_data;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         pc     <= '0;
         ir     <= NOP_WORD;
         busy   <= 1'b0;
         halted <= 1'b0;
      end else begin
         unique case (state)
            IDLE, HALTED: begin
               if (start) begin
                  pc     <= '0;
                  state  <= FETCH;
                  busy   <= 1'b1;
                  halted <= 1'b0;
               end
            end

            FETCH: begin
               ir <= fetch_word;
               if (fetch_is_halt) begin
                  // pc keeps pointing at the HALT word.
                  state  <= HALTED;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else begin
                  state <= ISSUE;
               end
            end

            ISSUE: begin
               if (done) begin
                  // Natural wrap from DEPTH-1 to 0.
                  pc <= pc + ADDR_W'(1);
                  if (step_mode) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= FETCH;
                  end
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // done is a registered FSM output, so gating on it forms no loop; it keeps
   // the FSM from re-decoding ir in its completion cycle.
   // NOTE: the default assignment first keeps this block latch-free.
   always_comb begin
      instruction = NOP_WORD;
      if ((state == ISSUE) && !done) begin
         instruction = ir;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch: reset state, halt on unloaded memory,
// multi-instruction run, single-step, dropped/accepted loads, pc wrap with
// ignored start pulses, asynchronous reset mid-run, and start+load in the same
// IDLE cycle.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   localparam logic [9:0] NOP   = 10'h380;
   localparam logic [9:0] HALT  = 10'h3C0;
   localparam logic [9:0] LOAD1 = 10'h008;
   localparam logic [9:0] MOVE  = 10'h051;
   localparam logic [9:0] ADD   = 10'h0D1;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_we;
   logic [3:0] load_addr;
   logic [9:0] load_data;
   logic       start;
   logic       step_mode;
   logic       done;
   logic [9:0] instruction;
   logic [3:0] pc;
   logic       busy;
   logic       halted;

   int checks = 0;
   int errors = 0;

   instr_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .load_we     (load_we),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .start       (start),
      .step_mode   (step_mode),
      .done        (done),
      .instruction (instruction),
      .pc          (pc),
      .busy        (busy),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; inputs and checks happen 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_word(input logic [3:0] addr, input logic [9:0] data);
      load_we   = 1'b1;
      load_addr = addr;
      load_data = data;
      tick();
      load_we   = 1'b0;
   endtask

   // start edge -> FETCH, next edge -> ISSUE or HALTED.
   task automatic run_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   // done edge -> FETCH (free run), next edge -> ISSUE or HALTED.
   task automatic pulse_done();
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
   endtask

   initial begin
      rst       = 1'b0;
      load_we   = 1'b0;
      load_addr = '0;
      load_data = '0;
      start     = 1'b0;
      step_mode = 1'b0;
      done      = 1'b0;
      #12;

      // ---- reset values
      check("reset_pc",     32'(pc),          32'h0);
      check("reset_instr",  32'(instruction), 32'(NOP));
      check("reset_busy",   32'(busy),        32'h0);
      check("reset_halted", 32'(halted),      32'h0);
      rst = 1'b1;
      tick();

      // ---- 1: unloaded memory halts immediately
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_fetch_busy",  32'(busy),        32'h1);
      check("t1_fetch_instr", 32'(instruction), 32'(NOP));
      tick();
      check("t1_halted", 32'(halted),      32'h1);
      check("t1_busy",   32'(busy),        32'h0);
      check("t1_pc",     32'(pc),          32'h0);
      check("t1_instr",  32'(instruction), 32'(NOP));

      // ---- 2: three-word program in free-run
      write_word(4'd0, LOAD1);
      write_word(4'd1, MOVE);
      write_word(4'd2, HALT);
      run_start();
      check("t2_issue0_instr",  32'(instruction), 32'(LOAD1));
      check("t2_issue0_pc",     32'(pc),          32'h0);
      check("t2_issue0_halted", 32'(halted),      32'h0);
      done = 1'b1;
      #1;
      check("t2_done_nop", 32'(instruction), 32'(NOP));
      tick();
      done = 1'b0;
      check("t2_bubble_nop", 32'(instruction), 32'(NOP));
      check("t2_bubble_pc",  32'(pc),          32'h1);
      tick();
      check("t2_issue1_instr", 32'(instruction), 32'(MOVE));
      check("t2_issue1_pc",    32'(pc),          32'h1);
      pulse_done();
      check("t2_halted", 32'(halted), 32'h1);
      check("t2_pc",     32'(pc),     32'h2);
      check("t2_busy",   32'(busy),   32'h0);
      // done outside ISSUE is ignored
      done = 1'b1;
      tick();
      done = 1'b0;
      check("t2_done_ignored_pc",     32'(pc),     32'h2);
      check("t2_done_ignored_halted", 32'(halted), 32'h1);

      // ---- 3: single-step
      step_mode = 1'b1;
      run_start();
      check("t3_issue0_instr", 32'(instruction), 32'(LOAD1));
      done = 1'b1;
      tick();
      done = 1'b0;
      check("t3_idle_pc",     32'(pc),          32'h1);
      check("t3_idle_busy",   32'(busy),        32'h0);
      check("t3_idle_halted", 32'(halted),      32'h0);
      check("t3_idle_instr",  32'(instruction), 32'(NOP));
      run_start();
      check("t3_restart_instr", 32'(instruction), 32'(LOAD1));
      check("t3_restart_pc",    32'(pc),          32'h0);
      step_mode = 1'b0;
      pulse_done();
      check("t3_issue1_instr", 32'(instruction), 32'(MOVE));
      pulse_done();
      check("t3_halted", 32'(halted), 32'h1);

      // ---- 4: load dropped in ISSUE, accepted in HALTED
      run_start();
      write_word(4'd0, ADD);
      check("t4_issue_instr_kept", 32'(instruction), 32'(LOAD1));
      pulse_done();
      pulse_done();
      check("t4_halted_a", 32'(halted), 32'h1);
      run_start();
      check("t4_mem0_unchanged", 32'(instruction), 32'(LOAD1));
      pulse_done();
      pulse_done();
      write_word(4'd0, ADD);
      run_start();
      check("t4_mem0_written", 32'(instruction), 32'(ADD));
      pulse_done();
      pulse_done();
      check("t4_halted_b", 32'(halted), 32'h1);

      // ---- 5: full memory, pc wrap, start ignored while busy
      for (int i = 0; i < 16; i++) begin
         write_word(4'(i), LOAD1);
      end
      run_start();
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t5_pc_%0d", i), 32'(pc), 32'(i));
         check($sformatf("t5_instr_%0d", i), 32'(instruction), 32'(LOAD1));
         if (i == 5) begin
            // start held through an ISSUE cycle, the done edge and FETCH
            start = 1'b1;
            tick();
            check("t5_start_in_issue_pc", 32'(pc), 32'h5);
            pulse_done();
            start = 1'b0;
         end else begin
            pulse_done();
         end
      end
      check("t5_wrap_pc",    32'(pc),          32'h0);
      check("t5_wrap_instr", 32'(instruction), 32'(LOAD1));
      check("t5_wrap_busy",  32'(busy),        32'h1);

      // ---- 6: asynchronous reset mid-run, memory re-initialised
      write_word(4'd0, ADD);  // dropped: still busy
      pulse_done();
      check("t6_pre_reset_pc", 32'(pc), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("t6_async_instr", 32'(instruction), 32'(NOP));
      check("t6_async_pc",    32'(pc),          32'h0);
      check("t6_async_busy",  32'(busy),        32'h0);
      tick();
      rst = 1'b1;
      tick();
      run_start();
      check("t6_post_halted", 32'(halted), 32'h1);
      check("t6_post_pc",     32'(pc),     32'h0);

      // ---- start and load in the same IDLE cycle
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      load_we   = 1'b1;
      load_addr = 4'd0;
      load_data = MOVE;
      start     = 1'b1;
      tick();
      load_we = 1'b0;
      start   = 1'b0;
      tick();
      check("t7_same_cycle_instr",  32'(instruction), 32'(MOVE));
      check("t7_same_cycle_halted", 32'(halted),      32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
